sbqm_teller_sched: RTL and testbench

Teller scheduler for the smart bank queue manager (SBqM). It tracks which tellers are free and chooses one eligible teller round-robin when a customer is waiting. It then issues a one-cycle `dequeue` pulse to the queue manager, which takes the place of the raw `forwardphoto` event, together with a one-hot `grant` to the chosen teller. Only the first `tcount` tellers are eligible, so the active-teller count used by the queue manager's wait-time computation also gates dispatch.

---
 rtl/sbqm_pkg.sv | 23 ++
 rtl/sbqm_rr_arbiter.sv | 42 ++++
 rtl/sbqm_teller_sched.sv | 151 +++++++++++++++
 tb/tb_sbqm_teller_sched.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sbqm_pkg.sv
// Shared constants, state encoding and helpers for the SBqM teller scheduler.
package sbqm_pkg;

    localparam int SBQM_NT    = 3;
    localparam int TCNT_W     = 2;
    localparam int SBQM_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        SETTLE = 2'd2
    } sbqm_state_e;

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_GRANT  = GRANT;
    localparam logic [1:0] ST_SETTLE = SETTLE;

    // Index width for an n-entry vector, never narrower than one bit
    function automatic int sbqm_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sbqm_rr_arbiter.sv
// Combinational round-robin pick over the eligible teller vector, starting at rr_ptr.
module sbqm_rr_arbiter
    import sbqm_pkg::*;
#(
    parameter int NT = SBQM_NT,
    parameter int PW = sbqm_idx_w(SBQM_NT)
) (
    input  logic [NT-1:0] elig,
    input  logic [PW-1:0] rr_ptr,
    output logic [NT-1:0] win_oh,
    output logic [PW-1:0] win_idx,
    output logic          win_vld
);

    int            sum_s;
    logic [PW-1:0] cand_s;
    logic          hit_s;

    // Scan offsets from farthest to nearest so the closest eligible teller at or after rr_ptr wins
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        win_oh  = '0;
        sum_s   = 0;
        cand_s  = '0;
        hit_s   = 1'b0;
        for (int k = NT - 1; k >= 0; k--) begin
            sum_s   = int'(rr_ptr) + k;
            sum_s   = (sum_s >= NT) ? (sum_s - NT) : sum_s;
            cand_s  = PW'(sum_s);
            hit_s   = elig[cand_s];
            win_idx = hit_s ? cand_s : win_idx;
            win_vld = hit_s | win_vld;
        end
        if (win_vld) begin
            win_oh[win_idx] = 1'b1;
        end else begin
            win_oh = '0;
        end
    end

endmodule

// File: rtl/sbqm_teller_sched.sv
// Teller scheduler: latches free-teller requests and dispatches them round-robin to the queue head.
// Per-teller saturating served counters are built only when SBQM_SERVED_CNT_EN is defined.
module sbqm_teller_sched
    import sbqm_pkg::*;
#(
    parameter int NT = SBQM_NT
`ifdef SBQM_SERVED_CNT_EN
    ,
    parameter int CNT_W = SBQM_CNT_W
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [TCNT_W-1:0] tcount,
    input  logic              empty,
    input  logic [NT-1:0]     teller_req,
    output logic              dequeue,
    output logic [NT-1:0]     grant,
    output logic [NT-1:0]     pending
`ifdef SBQM_SERVED_CNT_EN
    ,
    output logic [NT*CNT_W-1:0] served_cnt
`endif
);

    localparam int PW = sbqm_idx_w(NT);

    logic [1:0]    state_r;
    logic [NT-1:0] pending_r;
    logic [NT-1:0] grant_r;
    logic          dequeue_r;
    logic [PW-1:0] rr_ptr_r;
    logic [PW-1:0] win_idx_r;

    logic [NT-1:0] en_s;
    logic [NT-1:0] elig_s;
    logic [NT-1:0] win_oh_s;
    logic [PW-1:0] win_idx_s;
    logic          win_vld_s;
    logic          decide_s;
    logic [NT-1:0] clr_s;
    logic [PW-1:0] rr_next_s;

    // Eligibility: latched request of a teller below the active count
    always_comb begin
        en_s = '0;
        for (int i = 0; i < NT; i++) begin
            if (i < int'(tcount)) begin
                en_s[i] = 1'b1;
            end else begin
                en_s[i] = 1'b0;
            end
        end
        elig_s = pending_r & en_s;
    end

    sbqm_rr_arbiter #(
        .NT (NT),
        .PW (PW)
    ) u_arb (
        .elig    (elig_s),
        .rr_ptr  (rr_ptr_r),
        .win_oh  (win_oh_s),
        .win_idx (win_idx_s),
        .win_vld (win_vld_s)
    );

    // Commit decision, clear mask for the grant in flight, and the next pointer value
    always_comb begin
        decide_s  = (state_r == ST_IDLE) && win_vld_s && !empty;
        clr_s     = (state_r == ST_GRANT) ? grant_r : '0;
        rr_next_s = (win_idx_r == PW'(NT - 1)) ? '0 : (win_idx_r + PW'(1));
    end

    // Dispatch FSM; grant/dequeue are registered so they assert for exactly the GRANT cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            grant_r   <= '0;
            dequeue_r <= 1'b0;
            win_idx_r <= '0;
            rr_ptr_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (decide_s) begin
                        state_r   <= ST_GRANT;
                        grant_r   <= win_oh_s;
                        dequeue_r <= 1'b1;
                        win_idx_r <= win_idx_s;
                    end else begin
                        state_r   <= ST_IDLE;
                        grant_r   <= '0;
                        dequeue_r <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    state_r   <= ST_SETTLE;
                    grant_r   <= '0;
                    dequeue_r <= 1'b0;
                    rr_ptr_r  <= rr_next_s;
                end
                ST_SETTLE: begin
                    state_r   <= ST_IDLE;
                    grant_r   <= '0;
                    dequeue_r <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    grant_r   <= '0;
                    dequeue_r <= 1'b0;
                end
            endcase
        end
    end

    // Pending requests: a new request on the clearing edge keeps the bit set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_r <= '0;
        end else begin
            pending_r <= (pending_r & ~clr_s) | teller_req;
        end
    end

    assign dequeue = dequeue_r;
    assign grant   = grant_r;
    assign pending = pending_r;

`ifdef SBQM_SERVED_CNT_EN
    logic [NT*CNT_W-1:0] served_r;

    // Saturating served counters, bumped as each GRANT cycle ends
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            served_r <= '0;
        end else begin
            for (int i = 0; i < NT; i++) begin
                if (clr_s[i] && (served_r[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
                    served_r[i*CNT_W +: CNT_W] <= served_r[i*CNT_W +: CNT_W] + CNT_W'(1);
                end else begin
                    served_r[i*CNT_W +: CNT_W] <= served_r[i*CNT_W +: CNT_W];
                end
            end
        end
    end

    assign served_cnt = served_r;
`endif

endmodule

// File: tb/tb_sbqm_teller_sched.sv
// Self-checking bench for sbqm_teller_sched: timestamp-based reference model plus directed and random stimulus.
module tb_sbqm_teller_sched;

    localparam int TNT = 3;
`ifdef SBQM_SERVED_CNT_EN
    localparam int TCW = 2;
`else
    localparam int TCW = 8;
`endif
    localparam int CMAX = (1 << TCW) - 1;

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     tcount;
    logic           empty;
    logic [TNT-1:0] teller_req;
    logic           dequeue;
    logic [TNT-1:0] grant;
    logic [TNT-1:0] pending;
`ifdef SBQM_SERVED_CNT_EN
    logic [TNT*TCW-1:0] served_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    sbqm_teller_sched #(
        .NT (TNT)
`ifdef SBQM_SERVED_CNT_EN
        , .CNT_W (TCW)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tcount     (tcount),
        .empty      (empty),
        .teller_req (teller_req),
        .dequeue    (dequeue),
        .grant      (grant),
        .pending    (pending)
`ifdef SBQM_SERVED_CNT_EN
        , .served_cnt (served_cnt)
`endif
    );

    // Reference model: pending set, rotating pointer, and edge timestamps for the dispatch window
    logic [TNT-1:0] mp;
    logic [TNT-1:0] exp_g;
    logic           exp_d;
    int             rr, w, gend, next_dec, n;
    int             cnt [TNT];

    task automatic model_reset();
        mp = '0; exp_g = '0; exp_d = 1'b0;
        rr = 0; w = 0; gend = -10; next_dec = 0; n = 0;
        for (int i = 0; i < TNT; i++) cnt[i] = 0;
    endtask

    task automatic model_edge();
        logic [TNT-1:0] elig;
        bit decide;
        int win;
        if (reset) begin
            model_reset();
            return;
        end
        n++;
        elig = '0;
        for (int i = 0; i < TNT; i++) elig[i] = mp[i] && (i < int'(tcount));
        decide = (n >= next_dec) && (elig != '0) && !empty;
        win = -1;
        for (int k = 0; k < TNT; k++) begin
            if (win < 0 && elig[(rr + k) % TNT]) win = (rr + k) % TNT;
        end
        if (n == gend) begin
            mp[w] = 1'b0;
            rr = (w + 1) % TNT;
            if (cnt[w] < CMAX) cnt[w]++;
        end
        mp = mp | teller_req;
        if (decide) begin
            w = win;
            gend = n + 1;
            next_dec = n + 3;
            exp_g = TNT'(1) << win;
            exp_d = 1'b1;
        end else begin
            exp_g = '0;
            exp_d = 1'b0;
        end
    endtask

    always @(posedge reset) model_reset();
    always @(posedge clk) model_edge();

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Single compare process against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("grant", 32'(grant), 32'(exp_g));
            chk("dequeue", 32'(dequeue), 32'(exp_d));
            chk("pending", 32'(pending), 32'(mp));
`ifdef SBQM_SERVED_CNT_EN
            for (int i = 0; i < TNT; i++)
                chk("served_cnt", 32'(served_cnt[i*TCW +: TCW]), 32'(cnt[i]));
`endif
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [TNT-1:0] g [10];
        int dcnt;
        model_reset();
        reset = 1'b1; tcount = 2'd3; empty = 1'b0; teller_req = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_deq", 32'(dequeue), 32'd0);
        chk("rst_pend", 32'(pending), 32'd0);
        #2 reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // single request: grant two edges after the request edge
        teller_req = 3'b001; @(negedge clk); teller_req = 3'b000;
        chk("t1_pend", 32'(pending), 32'h1);
        chk("t1_model_pend", 32'(mp), 32'h1);
        @(negedge clk);
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_deq", 32'(dequeue), 32'h1);
        @(negedge clk);
        chk("t1_grant_off", 32'(grant), 32'h0);
        chk("t1_pend_clr", 32'(pending), 32'h0);
        repeat (2) @(negedge clk);

        // all three tellers: 001, 010, 100 three cycles apart, pointer wraps
        do_reset();
        teller_req = 3'b111; @(negedge clk); teller_req = 3'b000;
        dcnt = 0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            g[i] = grant;
            dcnt += int'(dequeue);
        end
        chk("t2_g1", 32'(g[1]), 32'h1);
        chk("t2_g4", 32'(g[4]), 32'h2);
        chk("t2_g7", 32'(g[7]), 32'h4);
        chk("t2_deq_count", 32'(dcnt), 32'd3);
        chk("t2_model_rr", 32'(rr), 32'd0);
        teller_req = 3'b011; @(negedge clk); teller_req = 3'b000;
        @(negedge clk);
        chk("t2_wrap_grant", 32'(grant), 32'h1);
        repeat (6) @(negedge clk);

        // disabled tellers stay latched until tcount rises
        do_reset();
        tcount = 2'd1;
        teller_req = 3'b110; @(negedge clk); teller_req = 3'b000;
        repeat (4) @(negedge clk);
        chk("t3_no_grant", 32'(grant), 32'h0);
        chk("t3_pend", 32'(pending), 32'h6);
        tcount = 2'd3;
        @(negedge clk);
        chk("t3_grant_a", 32'(grant), 32'h2);
        repeat (3) @(negedge clk);
        chk("t3_grant_b", 32'(grant), 32'h4);
        repeat (3) @(negedge clk);

        // empty queue holds off dispatch
        do_reset();
        empty = 1'b1;
        teller_req = 3'b001; @(negedge clk); teller_req = 3'b000;
        repeat (3) @(negedge clk);
        chk("t4_no_deq", 32'(dequeue), 32'h0);
        chk("t4_pend", 32'(pending), 32'h1);
        empty = 1'b0;
        @(negedge clk);
        chk("t4_grant", 32'(grant), 32'h1);
        repeat (3) @(negedge clk);

        // asynchronous reset in the middle of a grant
        do_reset();
        teller_req = 3'b001; @(negedge clk); teller_req = 3'b000;
        @(negedge clk);
        chk("t5_grant_before", 32'(grant), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("t5_async_grant", 32'(grant), 32'h0);
        chk("t5_async_deq", 32'(dequeue), 32'h0);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("t5_pend_after", 32'(pending), 32'h0);
        teller_req = 3'b100; @(negedge clk); teller_req = 3'b000;
        @(negedge clk);
        chk("t5_idle_grant", 32'(grant), 32'h4);
        repeat (3) @(negedge clk);

`ifdef SBQM_SERVED_CNT_EN
        // counter saturation after five grants to teller 0
        do_reset();
        for (int i = 0; i < 5; i++) begin
            teller_req = 3'b001; @(negedge clk); teller_req = 3'b000;
            repeat (2) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        chk("t6_sat", 32'(served_cnt[1:0]), 32'd3);
        chk("t6_other", 32'(served_cnt[TNT*TCW-1:2]), 32'd0);
`endif

        // randomized traffic
        do_reset();
        for (int c = 0; c < 600; c++) begin
            teller_req = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            empty = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 19) == 0) tcount = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        teller_req = 3'b000;
        empty = 1'b0;
        tcount = 2'd3;
        repeat (20) @(negedge clk);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
